// File: rtl/mm_dpram.sv
// True dual-port synchronous RAM for the modexp datapath. After every reset an init
// engine fills the array with INIT_VAL. User accesses are ignored until the fill is done.
module mm_dpram #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       WR_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  output logic              init_busy,
  output logic              collision
);

  localparam int unsigned DEPTH         = 2 ** ADDR_W;
  localparam int unsigned ModeReadFirst  = 1;
  localparam int unsigned ModeWriteFirst = 2;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                init_busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [DATA_W-1:0]   a_dout_q, a_dout_d;
  logic [DATA_W-1:0]   b_dout_q, b_dout_d;
  logic                a_valid_q, a_valid_d;
  logic                b_valid_q, b_valid_d;
  logic                coll_q, coll_d;

  logic                run;
  logic                same_addr;
  logic                a_rd, a_wr;
  logic                b_rd, b_wr, b_wr_eff;

  assign run       = (state_q == StRun);
  assign same_addr = (a_addr == b_addr);
  assign a_rd      = run && a_en && !a_we;
  assign a_wr      = run && a_en && a_we;
  assign b_rd      = run && b_en && !b_we;
  assign b_wr      = run && b_en && b_we;
  // Port A wins a same-address write/write conflict.
  assign b_wr_eff  = b_wr && !(a_wr && same_addr);

  // Init engine: one word per cycle from address 0, then hand over to the user ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= StRun;
            init_busy_q <= 1'b0;
          end
        end
        StRun: begin
          state_q     <= StRun;
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= StInit;
          cnt_q       <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= INIT_VAL;
    end else begin
      if (a_wr) begin
        mem[a_addr] <= a_din;
      end
      if (b_wr_eff) begin
        mem[b_addr] <= b_din;
      end
    end
  end

  // Array reads here see the pre-edge contents, so a cross-port reader always gets the old word.
  always_comb begin
    a_dout_d  = a_dout_q;
    a_valid_d = 1'b0;
    if (a_rd) begin
      a_dout_d  = mem[a_addr];
      a_valid_d = 1'b1;
    end else if (a_wr) begin
      if (WR_MODE == ModeReadFirst) begin
        a_dout_d  = mem[a_addr];
        a_valid_d = 1'b1;
      end else if (WR_MODE == ModeWriteFirst) begin
        a_dout_d  = a_din;
        a_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    b_dout_d  = b_dout_q;
    b_valid_d = 1'b0;
    if (b_rd) begin
      b_dout_d  = mem[b_addr];
      b_valid_d = 1'b1;
    end else if (b_wr) begin
      if (WR_MODE == ModeReadFirst) begin
        b_dout_d  = mem[b_addr];
        b_valid_d = 1'b1;
      end else if (WR_MODE == ModeWriteFirst) begin
        b_dout_d  = b_din;
        b_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    coll_d = run && a_en && b_en && same_addr && (a_we || b_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      a_dout_q  <= a_dout_d;
      b_dout_q  <= b_dout_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      coll_q    <= coll_d;
    end
  end

  assign a_dout    = a_dout_q;
  assign b_dout    = b_dout_q;
  assign a_valid   = a_valid_q;
  assign b_valid   = b_valid_q;
  assign collision = coll_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_mm_dpram.sv
// Directed bench for mm_dpram: three instances (WR_MODE 0/1/2) share one stimulus stream.
module tb_mm_dpram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_we, b_en, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic [15:0] a_dout [3];
  logic [15:0] b_dout [3];
  logic        a_valid [3];
  logic        b_valid [3];
  logic        init_busy [3];
  logic        collision [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mm_dpram #(
      .DATA_W   (16),
      .ADDR_W   (8),
      .WR_MODE  (g),
      .INIT_VAL (16'hA5A5)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_en      (a_en),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_din     (a_din),
      .a_dout    (a_dout[g]),
      .a_valid   (a_valid[g]),
      .b_en      (b_en),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_din     (b_din),
      .b_dout    (b_dout[g]),
      .b_valid   (b_valid[g]),
      .init_busy (init_busy[g]),
      .collision (collision[g])
    );
  end

  typedef struct {
    logic        ae, awe;
    logic [7:0]  aaddr;
    logic [15:0] adin;
    logic        be, bwe;
    logic [7:0]  baddr;
    logic [15:0] bdin;
    logic [15:0] ea;
    logic        eav;
    logic [15:0] eb;
    logic        ebv;
    logic        ec;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (init_busy[0] && n < 1000);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_a_dout"}, 32'(a_dout[d]), 32'h0);
      chk({tag, "_b_dout"}, 32'(b_dout[d]), 32'h0);
      chk({tag, "_a_valid"}, 32'(a_valid[d]), 32'h0);
      chk({tag, "_b_valid"}, 32'(b_valid[d]), 32'h0);
      chk({tag, "_coll"}, 32'(collision[d]), 32'h0);
      chk({tag, "_busy"}, 32'(init_busy[d]), 32'h1);
    end
  endtask

  initial begin
    int n;
    logic [15:0] pre_a [3];

    //        ae   awe  aaddr  adin      be   bwe  baddr  bdin      ea        eav  eb        ebv  ec
    vt[0]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000,
               16'h0000, 1'b0, 16'hA5A5, 1'b1, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h7F, 16'h0000,
               16'h0000, 1'b0, 16'hA5A5, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'hFF, 16'h0000,
               16'h0000, 1'b0, 16'hA5A5, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000,
               16'h0000, 1'b0, 16'hA5A5, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h12, 16'h0000,
               16'h0000, 1'b0, 16'hBEEF, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
               16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 8'h03, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
               16'hA5A5, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 8'h40, 16'h0A0A, 1'b1, 1'b1, 8'h40, 16'h0B0B,
               16'hA5A5, 1'b0, 16'hBEEF, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
               16'hA5A5, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
               16'h0A0A, 1'b1, 16'hBEEF, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h41, 16'h0000,
               16'h0A0A, 1'b0, 16'hBEEF, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 8'h41, 16'hCAFE, 1'b1, 1'b0, 8'h41, 16'h0000,
               16'h0A0A, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[12] = '{1'b1, 1'b0, 8'h41, 16'h0000, 1'b1, 1'b0, 8'h41, 16'h0000,
               16'hCAFE, 1'b1, 16'hCAFE, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b1, 8'h05, 16'h1111, 1'b0, 1'b0, 8'h00, 16'h0000,
               16'hCAFE, 1'b0, 16'hCAFE, 1'b0, 1'b0};

    idle();
    rst_n = 1'b0;
    step();
    step();
    chk_reset_vals("rst");

    // Release reset; attempt a write to 0x03 (and a B write, same address) mid-init.
    #2 rst_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 2) begin
        a_en = 1'b1; a_we = 1'b1; a_addr = 8'h03; a_din = 16'h1234;
        b_en = 1'b1; b_we = 1'b1; b_addr = 8'h03; b_din = 16'h5678;
      end else if (n == 3) begin
        chk("init_a_valid", 32'(a_valid[0]), 32'h0);
        chk("init_b_valid", 32'(b_valid[0]), 32'h0);
        chk("init_a_dout", 32'(a_dout[0]), 32'h0);
        chk("init_coll", 32'(collision[0]), 32'h0);
        idle();
      end
    end while (init_busy[0] && n < 1000);
    chk("init_len", 32'(n), 32'd256);

    for (int i = 0; i < 14; i++) begin
      a_en = vt[i].ae; a_we = vt[i].awe; a_addr = vt[i].aaddr; a_din = vt[i].adin;
      b_en = vt[i].be; b_we = vt[i].bwe; b_addr = vt[i].baddr; b_din = vt[i].bdin;
      step();
      chk($sformatf("v%0d_a_dout", i), 32'(a_dout[0]), 32'(vt[i].ea));
      chk($sformatf("v%0d_a_valid", i), 32'(a_valid[0]), 32'(vt[i].eav));
      chk($sformatf("v%0d_b_dout", i), 32'(b_dout[0]), 32'(vt[i].eb));
      chk($sformatf("v%0d_b_valid", i), 32'(b_valid[0]), 32'(vt[i].ebv));
      chk($sformatf("v%0d_coll", i), 32'(collision[0]), 32'(vt[i].ec));
    end
    idle();

    // WR_MODE sweep: park a_dout at a known word, then overwrite 0x05 (holding 0x1111).
    a_en = 1'b1; a_addr = 8'h03;
    step();
    for (int d = 0; d < 3; d++) pre_a[d] = a_dout[d];
    chk("sweep_pre", 32'(pre_a[0]), 32'hA5A5);
    a_we = 1'b1; a_addr = 8'h05; a_din = 16'h2222;
    step();
    chk("m0_a_dout", 32'(a_dout[0]), 32'hA5A5);
    chk("m0_a_valid", 32'(a_valid[0]), 32'h0);
    chk("m1_a_dout", 32'(a_dout[1]), 32'h1111);
    chk("m1_a_valid", 32'(a_valid[1]), 32'h1);
    chk("m2_a_dout", 32'(a_dout[2]), 32'h2222);
    chk("m2_a_valid", 32'(a_valid[2]), 32'h1);
    a_we = 1'b0;
    step();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("m%0d_readback", d), 32'(a_dout[d]), 32'h2222);
      chk($sformatf("m%0d_rb_valid", d), 32'(a_valid[d]), 32'h1);
    end
    idle();
    step();
    chk("valid_drop", 32'(a_valid[0]), 32'h0);
    chk("dout_hold", 32'(a_dout[0]), 32'h2222);

    // Reset mid-init: restart, pulse reset after 100 init cycles.
    rst_n = 1'b0;
    #2 chk("rst2_a_dout", 32'(a_dout[0]), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk("mid_busy", 32'(init_busy[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    step();
    rst_n = 1'b1;
    wait_init(n);
    chk("reinit_len", 32'(n), 32'd256);

    // Every word must read back as INIT_VAL on every instance.
    b_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b_addr = 8'(i);
      step();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("fill_m%0d_%0h", d, i), 32'(b_dout[d]), 32'hA5A5);
        chk($sformatf("fill_v%0d_%0h", d, i), 32'(b_valid[d]), 32'h1);
      end
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mm_dpram.md
Name: mm_dpram

Overview:
- Parametrised true dual-port synchronous RAM for the modexp datapath, holding Montgomery-multiplier operands and constants.
- Both ports can read and write, with a selectable write/read mode, per-port read-valid strobes and cross-port collision arbitration.
- A built-in init engine clears the array to a constant after reset, so the multiplier never consumes stale words.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- WR_MODE, 0, port read behaviour on a write cycle:
  - 0 = NO_CHANGE: dout holds, no valid.
  - 1 = READ_FIRST: old word returned.
  - 2 = WRITE_FIRST: new word returned.
- INIT_VAL, 0, DATA_W-bit value written to every word by the init engine.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_en  in  1  port A access enable.
- a_we  in  1  port A write enable (qualified by a_en).
- a_addr  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A registered read data.
- a_valid  out  1  a_dout updated this cycle.
- b_en  in  1  port B access enable.
- b_we  in  1  port B write enable (qualified by b_en).
- b_addr  in  ADDR_W  port B address.
- b_din  in  DATA_W  port B write data.
- b_dout  out  DATA_W  port B registered read data.
- b_valid  out  1  b_dout updated this cycle.
- init_busy  out  1  init engine running; user accesses ignored.
- collision  out  1  one-cycle pulse on a same-address cross-port conflict.

Behaviour:
- Reset, while rst_n = 0 (asynchronous):
  - a_dout = b_dout = 0; a_valid = b_valid = 0; collision = 0.
  - init_busy = 1; init counter = 0.
  - Array contents are not cleared asynchronously.
- Init FSM, states INIT and RUN:
  - INIT: each cycle writes INIT_VAL to mem[cnt], cnt++.
  - On the write of address DEPTH-1, the next state is RUN and init_busy drops. INIT lasts exactly DEPTH cycles after rst_n rises.
  - In INIT, a_en/b_en are ignored: no writes, no valid, douts hold.
  - Reset asserted mid-init restarts INIT from address 0.
- Read latency is 1 cycle. For port X (A or B), when X_en=1, X_we=0 and the FSM is in RUN:
  - X_dout <= mem[X_addr] at the edge.
  - X_valid = 1 for exactly the following cycle.
- Write, when X_en=1 and X_we=1 in RUN:
  - mem[X_addr] <= X_din.
  - Output by WR_MODE: 0 → X_dout holds, X_valid = 0. 1 → old word, X_valid = 1. 2 → X_din, X_valid = 1.
- When X_en=0, X_dout holds its last value and X_valid = 0.
- Cross-port rules, same address, same cycle, in RUN:
  - Both ports write: port A wins, port B's write is dropped, collision = 1 next cycle.
  - One port writes, the other reads: the reader gets the OLD word regardless of WR_MODE, collision = 1 next cycle.
  - Both ports read: no conflict, collision = 0.
- collision is a single-cycle pulse, re-asserted for each conflicting cycle, and never asserted during INIT.
- No address bounds check is needed: the address width covers exactly DEPTH words.

Test Plan:
- Reset, DEPTH=256, INIT_VAL=16'hA5A5: release rst_n → init_busy=1 for 256 cycles then 0; reads of addr 0x00, 0x7F, 0xFF → 16'hA5A5 with b_valid one cycle after b_en.
- Port A writes 0x12 = 16'hBEEF; next cycle port B reads 0x12 → b_dout = 16'hBEEF, b_valid = 1 exactly one cycle after the request, then 0.
- WR_MODE sweep: mem[0x05] = 16'h1111, port A writes 16'h2222 to 0x05:
  - WR_MODE=0 → a_dout unchanged, a_valid = 0.
  - WR_MODE=1 → a_dout = 16'h1111, a_valid = 1.
  - WR_MODE=2 → a_dout = 16'h2222, a_valid = 1.
  - All three → a later read returns 16'h2222.
- Collisions:
  - A writes 16'h0A0A and B writes 16'h0B0B to 0x40 in the same cycle → collision pulses once; a read of 0x40 returns 16'h0A0A.
  - A writes 16'hCAFE to 0x41 (old 16'h0000) while B reads 0x41 → b_dout = 16'h0000, collision = 1.
- Access during init: a_en=1, a_we=1, a_addr=0x03 at init cycle 2 → write ignored, a_valid = 0; after init, mem[0x03] = INIT_VAL.
- Reset mid-init: pulse rst_n low at init cycle 100 → outputs return to reset values immediately; init_busy stays 1 for a full 256 cycles after release; all words read back as INIT_VAL.
